// File: rtl/qos_multimode_arbiter.sv
// Multi-policy N-requester arbiter: fixed, round-robin, class+aging and weighted
// round-robin, with a starvation override and a registered one-hot grant held until accepted.
module qos_multimode_arbiter #(
  parameter int N        = 8,
  parameter int CLASS_W  = 2,
  parameter int AGE_W    = 4,
  parameter int WEIGHT_W = 4,
  parameter int FAIR_K   = 8,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       mode,
  input  logic [N-1:0]                     req,
  input  logic [N-1:0][CLASS_W-1:0]        class_prio,
  input  logic [N-1:0][WEIGHT_W-1:0]       weight,
  input  logic                             gnt_ready,
  output logic [N-1:0]                     gnt,
  output logic [IDX_W-1:0]                 gnt_idx,
  output logic                             gnt_valid,
  output logic [N-1:0]                     starve
);

  localparam int          WAIT_W = $clog2(FAIR_K + 1);
  localparam int unsigned N_U    = N;

  typedef enum logic {ARB, GRANT} state_t;
  typedef enum logic [1:0] {M_FIXED = 2'd0, M_RR = 2'd1, M_CLASS_AGE = 2'd2, M_WRR = 2'd3} mode_t;

  state_t                     state, state_n;
  mode_t                      cur_mode, mode_n;
  logic [IDX_W-1:0]           rr_ptr, ptr_n, win, nxt_ptr, gnt_idx_n;
  logic [WEIGHT_W-1:0]        credit, credit_n, cur_credit, wrr_rem;
  logic [N-1:0][AGE_W-1:0]    age, age_n;
  logic [N-1:0][WAIT_W-1:0]   wait_cnt, wait_n;
  logic [N-1:0]               gnt_n, starve_n;
  logic                       gnt_valid_n, xfer, found;
  logic [CLASS_W-1:0]         best_c;
  logic [AGE_W-1:0]           best_a;

  function automatic logic [WEIGHT_W-1:0] eff_w(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  assign xfer = (state == GRANT) && gnt_valid && gnt_ready;

  // Winner from registered state; starvation override has first say in every mode.
  always_comb begin
    win    = '0;
    found  = 1'b0;
    best_c = '0;
    best_a = '0;
    for (int unsigned i = 0; i < N_U; i++) begin
      if (!found && starve[i] && req[i]) begin
        win   = IDX_W'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      case (mode_t'(mode))
        M_FIXED: begin
          for (int unsigned i = 0; i < N_U; i++) begin
            if (!found && req[i]) begin
              win   = IDX_W'(i);
              found = 1'b1;
            end
          end
        end
        M_CLASS_AGE: begin
          for (int unsigned i = 0; i < N_U; i++) begin
            if (req[i] && (!found || class_prio[i] > best_c ||
                           (class_prio[i] == best_c && age[i] > best_a))) begin
              win    = IDX_W'(i);
              best_c = class_prio[i];
              best_a = age[i];
              found  = 1'b1;
            end
          end
        end
        default: begin
          for (int unsigned k = 0; k < N_U; k++) begin
            if (!found && req[(32'(rr_ptr) + k) % N_U]) begin
              win   = IDX_W'((32'(rr_ptr) + k) % N_U);
              found = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    mode_n      = cur_mode;
    gnt_n       = gnt;
    gnt_idx_n   = gnt_idx;
    gnt_valid_n = gnt_valid;
    ptr_n       = rr_ptr;
    credit_n    = credit;
    age_n       = age;
    wait_n      = wait_cnt;
    starve_n    = '0;
    // Zero credit only exists before the first WRR transfer: read it as a full quantum.
    cur_credit  = (credit == '0) ? eff_w(weight[rr_ptr]) : credit;
    nxt_ptr     = (32'(gnt_idx) == N_U - 1) ? '0 : gnt_idx + 1'b1;
    wrr_rem     = eff_w(weight[gnt_idx]) - 1'b1;

    case (state)
      ARB: begin
        if (|req) begin
          state_n      = GRANT;
          mode_n       = mode_t'(mode);
          gnt_n        = '0;
          gnt_n[win]   = 1'b1;
          gnt_idx_n    = win;
          gnt_valid_n  = 1'b1;
        end
      end
      GRANT: begin
        if (xfer) begin
          state_n     = ARB;
          gnt_n       = '0;
          gnt_idx_n   = '0;
          gnt_valid_n = 1'b0;
          case (cur_mode)
            M_RR: ptr_n = nxt_ptr;
            M_WRR: begin
              if (gnt_idx == rr_ptr && cur_credit > WEIGHT_W'(1)) begin
                credit_n = cur_credit - 1'b1;
              end else if (gnt_idx == rr_ptr || wrr_rem == '0) begin
                ptr_n    = nxt_ptr;
                credit_n = eff_w(weight[nxt_ptr]);
              end else begin
                ptr_n    = gnt_idx;
                credit_n = wrr_rem;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_n = ARB;
    endcase

    for (int unsigned i = 0; i < N_U; i++) begin
      if (xfer && gnt_idx == IDX_W'(i)) begin
        age_n[i] = '0;
      end else if (req[i] && !(gnt_valid && gnt[i]) && age[i] != '1) begin
        age_n[i] = age[i] + 1'b1;
      end
      if (xfer) begin
        if (gnt_idx == IDX_W'(i) || !req[i]) begin
          wait_n[i] = '0;
        end else if (wait_cnt[i] < WAIT_W'(FAIR_K)) begin
          wait_n[i] = wait_cnt[i] + 1'b1;
        end
      end
      starve_n[i] = (wait_n[i] >= WAIT_W'(FAIR_K));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB;
      cur_mode  <= M_FIXED;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      starve    <= '0;
      rr_ptr    <= '0;
      credit    <= '0;
      age       <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_n;
      cur_mode  <= mode_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
      starve    <= starve_n;
      rr_ptr    <= ptr_n;
      credit    <= credit_n;
      age       <= age_n;
      wait_cnt  <= wait_n;
    end
  end

endmodule

// File: tb/tb_qos_multimode_arbiter.sv
// Scoreboard bench for qos_multimode_arbiter (N=4): a queue-based reference model
// predicts every grant and the starve vector; directed sequences plus random traffic.
module tb_qos_multimode_arbiter;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [N-1:0]     req = '0;
  logic [N-1:0][1:0] class_prio = '0;
  logic [N-1:0][3:0] weight = '0;
  logic             gnt_ready = 1'b0;
  logic [N-1:0]     gnt;
  logic [1:0]       gnt_idx;
  logic             gnt_valid;
  logic [N-1:0]     starve;

  int checks = 0;
  int errors = 0;

  qos_multimode_arbiter #(
    .N(N), .CLASS_W(2), .AGE_W(4), .WEIGHT_W(4), .FAIR_K(8)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .req(req), .class_prio(class_prio),
    .weight(weight), .gnt_ready(gnt_ready), .gnt(gnt), .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, expressed with plain integers.
  int          m_valid, m_gnt, m_mode, m_ptr, m_credit;
  int          m_age[N];
  int          m_wait[N];
  logic [N-1:0] m_starve;
  int          exp_q[$];
  int          seen_q[$];

  function automatic int effw(input int i);
    return (weight[i] == 0) ? 1 : int'(weight[i]);
  endfunction

  function automatic int pick(input int md);
    int best;
    for (int i = 0; i < N; i++) if (m_starve[i] && req[i]) return i;
    if (md == 0) begin
      for (int i = 0; i < N; i++) if (req[i]) return i;
    end else if (md == 2) begin
      best = -1;
      for (int i = 0; i < N; i++)
        if (req[i] && (best < 0 || class_prio[i] > class_prio[best] ||
                       (class_prio[i] == class_prio[best] && m_age[i] > m_age[best])))
          best = i;
      return best;
    end else begin
      for (int k = 0; k < N; k++) if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_gnt = 0; m_mode = 0; m_ptr = 0; m_credit = 0; m_starve = '0;
    for (int i = 0; i < N; i++) begin m_age[i] = 0; m_wait[i] = 0; end
    exp_q.delete();
  endtask

  task automatic model_step();
    int nw, w, c;
    bit xfer;
    nw   = -1;
    w    = m_gnt;
    xfer = (m_valid != 0) && gnt_ready;
    if (m_valid == 0 && req != 0) nw = pick(int'(mode));
    for (int i = 0; i < N; i++) begin
      if (xfer && i == w) m_age[i] = 0;
      else if (req[i] && !(m_valid != 0 && i == m_gnt)) m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
    end
    if (xfer) begin
      if (m_mode == 1) m_ptr = (w + 1) % N;
      if (m_mode == 3) begin
        if (w == m_ptr) begin
          c = (m_credit == 0) ? effw(m_ptr) : m_credit;
          if (c > 1) m_credit = c - 1;
          else begin m_ptr = (w + 1) % N; m_credit = effw(m_ptr); end
        end else if (effw(w) - 1 == 0) begin
          m_ptr = (w + 1) % N; m_credit = effw(m_ptr);
        end else begin
          m_ptr = w; m_credit = effw(w) - 1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (i == w || !req[i]) m_wait[i] = 0;
        else if (m_wait[i] < 8) m_wait[i] = m_wait[i] + 1;
        m_starve[i] = (m_wait[i] >= 8);
      end
      m_valid = 0;
    end
    if (nw >= 0) begin
      exp_q.push_back(nw);
      m_valid = 1; m_gnt = nw; m_mode = int'(mode);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  // Monitor: compares handshake and starve each cycle, pops expected grants on each new grant.
  initial begin
    int prev_v, e;
    logic [N-1:0] held;
    prev_v = 0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        chk("valid", int'(gnt_valid), m_valid);
        chk("starve", int'(starve), int'(m_starve));
        if (gnt_valid && prev_v == 0) begin
          if (exp_q.size() == 0) chk("grant_unexpected", int'(gnt_idx), -1);
          else begin
            e = exp_q.pop_front();
            chk("grant_idx", int'(gnt_idx), e);
            chk("grant_onehot", int'(gnt), 1 << e);
          end
          seen_q.push_back(int'(gnt_idx));
          held = gnt;
        end else if (gnt_valid) begin
          chk("grant_hold", int'(gnt), int'(held));
        end
        prev_v = int'(gnt_valid);
      end else begin
        prev_v = 0;
      end
    end
  end

  task automatic do_reset();
    req = '0; gnt_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    seen_q.delete();
  endtask

  task automatic wait_seen(input string name, input int n);
    int cyc;
    cyc = 0;
    while (seen_q.size() < n && cyc < 300) begin @(negedge clk); cyc++; end
    if (seen_q.size() < n) chk({name, "_timeout"}, seen_q.size(), n);
  endtask

  task automatic run_seq(input string name, input logic [1:0] md, input logic [N-1:0] rq,
                         input int e[10], input int n);
    do_reset();
    mode = md; req = rq; gnt_ready = 1'b1;
    wait_seen(name, n);
    req = '0;
    for (int i = 0; i < n; i++)
      if (i < seen_q.size()) chk(name, seen_q[i], e[i]);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int e[10];
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[10];
    // Reset state and asynchronous reset mid-grant
    do_reset();
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_starve", int'(starve), 0);
    mode = 2'd0; req = 4'b0001; gnt_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", int'(gnt_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_gnt", int'(gnt), 0);
    chk("async_rst_valid", int'(gnt_valid), 0);
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_gnt", int'(gnt), 0);
    chk("idle_valid", int'(gnt_valid), 0);

    // FIXED with starvation of requester 3
    e = '{1, 1, 1, 1, 1, 1, 1, 1, 3, 1};
    run_seq("fixed_seq", 2'd0, 4'b1010, e, 10);

    // RR
    e = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0};
    run_seq("rr_seq", 2'd1, 4'b1111, e, 5);

    // WRR with weights 3,1,2,1
    weight[0] = 4'd3; weight[1] = 4'd1; weight[2] = 4'd2; weight[3] = 4'd1;
    e = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
    run_seq("wrr_seq", 2'd3, 4'b1111, e, 8);

    // CLASS_AGE with classes 1,2,2,0
    class_prio[0] = 2'd1; class_prio[1] = 2'd2; class_prio[2] = 2'd2; class_prio[3] = 2'd0;
    e = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    run_seq("cls_seq", 2'd2, 4'b1111, e, 2);

    // Hold: grant stays while not ready; mode change during hold applies at next ARB
    do_reset();
    mode = 2'd1; req = 4'b0100; gnt_ready = 1'b0;
    wait_seen("hold_first", 1);
    req = '0; mode = 2'd0;
    repeat (5) @(negedge clk);
    chk("hold_valid", int'(gnt_valid), 1);
    chk("hold_gnt", int'(gnt), 4);
    gnt_ready = 1'b1;
    @(negedge clk);
    gnt_ready = 1'b0;
    chk("post_xfer_valid", int'(gnt_valid), 0);
    mode = 2'd1; req = 4'b1001; gnt_ready = 1'b1;
    wait_seen("hold_next", 2);
    req = '0;
    if (seen_q.size() >= 2) chk("hold_next_idx", seen_q[1], 3);
    repeat (4) @(negedge clk);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      gnt_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0)
        for (int i = 0; i < N; i++) begin
          class_prio[i] = 2'($urandom);
          weight[i] = 4'($urandom);
        end
      @(negedge clk);
    end
    req = '0; gnt_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
